// File: rtl/tribus_pkg.sv
// Shared types and constants for the tristate bus arbiter.
// Holds the FSM state type, default parameter values and the owner-index width helper.
package tribus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      TURN
   } state_t;

   localparam int N_REQ_DEF    = 4;
   localparam int MAX_HOLD_DEF = 8;
   localparam int TURN_CYC_DEF = 1;

   // A two-requester bus still needs one bit of owner index.
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tribus_arbiter_if.sv
// Request/ownership bundle between requesters, the arbiter and the bus driver enables.
// The arbiter connects through master; a requester-side model connects through slave.
interface tribus_arbiter_if
   import tribus_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        grant;
   logic [N_REQ-1:0]        drv_en;
   logic [id_w(N_REQ)-1:0]  owner_id;
   logic                    owner_valid;
   logic                    bus_turn;

   modport master (
      input  req,
      output grant,
      output drv_en,
      output owner_id,
      output owner_valid,
      output bus_turn
   );

   modport slave (
      output req,
      input  grant,
      input  drv_en,
      input  owner_id,
      input  owner_valid,
      input  bus_turn
   );
endinterface

// File: rtl/tribus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after the last owner, with wrap.
// Walks from the farthest candidate to the nearest so the nearest set bit wins.
module rr_picker
   import tribus_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   localparam int IW    = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    win,
   output logic             vld
);
   logic [IW-1:0] idx;

   always_comb begin
      win = '0;
      vld = 1'b0;
      idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = IW'((int'(last) + i) % N_REQ);
         if (req[idx]) begin
            win = idx;
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with bounded tenure and
// a dead-bus turnaround gap so two driver enables can never overlap.
module tribus_arbiter
   import tribus_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int TURN_CYC = TURN_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   tribus_arbiter_if.master bus
);
   localparam int IW     = id_w(N_REQ);
   localparam int TEN_W  = $clog2(MAX_HOLD + 1);
   localparam int TURN_W = $clog2(TURN_CYC + 1);
   localparam logic [TEN_W-1:0]  MAX_T  = TEN_W'(MAX_HOLD);
   localparam logic [TURN_W-1:0] TURN_T = TURN_W'(TURN_CYC);

   state_t              state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [IW-1:0]       id_q, id_d;
   logic [TEN_W-1:0]    ten_q, ten_d;
   logic [TURN_W-1:0]   turn_q, turn_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic                valid_q, valid_d;
   logic                bturn_q, bturn_d;

   logic [IW-1:0]       pick_id;
   logic                pick_vld;
   logic                do_arb;
   logic                rel;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req  (bus.req),
      .last (last_q),
      .win  (pick_id),
      .vld  (pick_vld)
   );

   // Release when the owner lets go, or when its tenure is used up and someone else waits.
   assign rel = !bus.req[id_q] ||
                ((ten_q == MAX_T) && (|(bus.req & ~grant_q)));

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      ten_d   = ten_q;
      turn_d  = turn_q;
      grant_d = grant_q;
      valid_d = valid_q;
      bturn_d = bturn_q;
      do_arb  = 1'b0;

      unique case (state_q)
         IDLE: do_arb = 1'b1;
         OWN: begin
            if (rel) begin
               state_d = TURN;
               grant_d = '0;
               valid_d = 1'b0;
               bturn_d = 1'b1;
               turn_d  = TURN_T;
            end else begin
               ten_d = (ten_q == MAX_T) ? ten_q : ten_q + 1'b1;
            end
         end
         TURN: begin
            if (turn_q == TURN_W'(1)) begin
               do_arb  = 1'b1;
               bturn_d = 1'b0;
               state_d = IDLE;
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_arb && pick_vld) begin
         state_d = OWN;
         grant_d = N_REQ'(1) << pick_id;
         id_d    = pick_id;
         last_d  = pick_id;
         ten_d   = TEN_W'(1);
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= IW'(N_REQ - 1);
         id_q    <= '0;
         ten_q   <= '0;
         turn_q  <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         bturn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         ten_q   <= ten_d;
         turn_q  <= turn_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         bturn_q <= bturn_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.drv_en      = grant_q;
   assign bus.owner_id    = id_q;
   assign bus.owner_valid = valid_q;
   assign bus.bus_turn    = bturn_q;

`ifndef SYNTHESIS
   // Dead cycles seen since the last enabled cycle, saturating at TURN_CYC.
   int               gap_cnt;
   logic [N_REQ-1:0] prev_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= TURN_CYC;
         prev_en <= '0;
      end else if (|bus.drv_en) begin
         gap_cnt <= 0;
         prev_en <= bus.drv_en;
      end else if (gap_cnt < TURN_CYC) begin
         gap_cnt <= gap_cnt + 1;
      end
   end

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.drv_en));
   a_en_eq:  assert property (@(posedge clk) disable iff (!rst_n) bus.drv_en == bus.grant);
   a_valid:  assert property (@(posedge clk) disable iff (!rst_n) bus.owner_valid == (|bus.grant));
   a_excl:   assert property (@(posedge clk) disable iff (!rst_n) !(bus.bus_turn && bus.owner_valid));
   a_gap:    assert property (@(posedge clk) disable iff (!rst_n)
                (|bus.drv_en) |-> ((gap_cnt == 0 && bus.drv_en == prev_en) || gap_cnt >= TURN_CYC));
`endif

endmodule
